// File: rtl/slow_clk_period_meter_pkg.sv
// Shared definitions for the slow-clock period meter: FSM states, default widths
// and a most-significant-set-bit priority encoder.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } meas_state_t;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_OFF_W = 5;

  // floor(log2(v)) as the index of the highest set bit; 0 for v == 0
  function automatic logic [6:0] msb_index(input logic [63:0] v);
    logic [6:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = i[6:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge detect on
// the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/slow_clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk cycles and
// decodes which divider counter bit would produce that period.
module slow_clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int OFF_W = DEF_OFF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             meas_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             pow2,
  output logic [OFF_W-1:0] offset,
  output logic             duty_ok
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Handshake: start is a one-cycle request honoured only in IDLE (or with ack
  // in DONE); meas_valid stays high until ack, which is ignored elsewhere.

  meas_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hcnt, hcnt_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             meas_valid_n, timeout_n, pow2_n, duty_n;
  logic [OFF_W-1:0] offset_n;

  logic             s2;
  logic             rise;

  logic             load;
  logic [CNT_W-1:0] res_period;
  logic [CNT_W-1:0] res_high;
  logic             res_timeout;
  logic [CNT_W-1:0] cnt_inc;
  logic             is_p2;
  logic [6:0]       lg;
  logic [6:0]       lg_m1;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (s2),
    .rise  (rise)
  );

  assign busy = (state == WAIT_EDGE) || (state == MEASURE);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hcnt_n       = hcnt;
    period_n     = period;
    high_n       = high_time;
    meas_valid_n = meas_valid;
    timeout_n    = timeout;
    pow2_n       = pow2;
    offset_n     = offset;
    duty_n       = duty_ok;
    load         = 1'b0;
    res_period   = '0;
    res_high     = '0;
    res_timeout  = 1'b0;
    cnt_inc      = cnt + CNT_ONE;
    is_p2        = 1'b0;
    lg           = '0;
    lg_m1        = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = WAIT_EDGE;
          cnt_n     = '0;
          hcnt_n    = '0;
          timeout_n = 1'b0;
        end
      end
      WAIT_EDGE: begin
        // The partial first period is thrown away; rise cycle counts as cycle 1.
        if (rise) begin
          state_n = MEASURE;
          cnt_n   = CNT_ONE;
          hcnt_n  = CNT_ONE;
        end else if (cnt_inc == CNT_MAX) begin
          load        = 1'b1;
          res_period  = CNT_MAX;
          res_high    = '0;
          res_timeout = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      MEASURE: begin
        if (rise) begin
          load       = 1'b1;
          res_period = cnt;
          res_high   = hcnt;
        end else if (cnt == CNT_MAX) begin
          load        = 1'b1;
          res_period  = CNT_MAX;
          res_high    = hcnt;
          res_timeout = 1'b1;
        end else begin
          cnt_n = cnt_inc;
          if (s2) hcnt_n = hcnt + CNT_ONE;
        end
      end
      DONE: begin
        if (ack && start) begin
          state_n      = WAIT_EDGE;
          cnt_n        = '0;
          hcnt_n       = '0;
          timeout_n    = 1'b0;
          meas_valid_n = 1'b0;
        end else if (ack) begin
          state_n      = IDLE;
          timeout_n    = 1'b0;
          meas_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Decode is taken from the value being loaded so it lands with meas_valid.
    if (load) begin
      is_p2        = (res_period != '0) && ((res_period & (res_period - CNT_ONE)) == '0)
                     && (res_period != CNT_ONE);
      lg           = msb_index(64'(res_period));
      lg_m1        = lg - 7'd1;
      state_n      = DONE;
      period_n     = res_period;
      high_n       = res_high;
      meas_valid_n = 1'b1;
      timeout_n    = res_timeout;
      pow2_n       = is_p2 && !res_timeout;
      offset_n     = (is_p2 && !res_timeout) ? OFF_W'(lg_m1) : '0;
      duty_n       = !res_timeout && ({res_high, 1'b0} == {1'b0, res_period});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      pow2       <= 1'b0;
      offset     <= '0;
      duty_ok    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hcnt       <= hcnt_n;
      period     <= period_n;
      high_time  <= high_n;
      meas_valid <= meas_valid_n;
      timeout    <= timeout_n;
      pow2       <= pow2_n;
      offset     <= offset_n;
      duty_ok    <= duty_n;
    end
  end

endmodule
